riscv_decode_stage: RTL

Decode pipeline stage that produces operand-2 selection and sign-extended immediates for the execute-stage operand-2 multiplexer. It accepts fetched instructions over a valid/ready handshake, reads the rs2 register value, extracts the I/S/J immediates, and holds results in a 2-entry skid buffer. Results are presented to execute over a second valid/ready handshake. It sits between fetch and execute and is the producer side of the `op2_sel`/`rs2_data`/`imm_*_sext` interface.

---
 rtl/riscv_decode_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/riscv_decode_stage.sv
// Decode stage: rs2 read, I/S/J immediate extraction and operand-2 select,
// buffered in a 2-entry skid buffer between fetch and execute.
module riscv_decode_stage #(
    parameter int unsigned WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_inst,
    input  logic [WORD_LENGTH-1:0] in_pc,
    input  logic                   flush,
    output logic [4:0]             rs2_addr,
    input  logic [WORD_LENGTH-1:0] rs2_rdata,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             op2_sel,
    output logic [WORD_LENGTH-1:0] rs2_data,
    output logic [WORD_LENGTH-1:0] imm_i_sext,
    output logic [WORD_LENGTH-1:0] imm_s_sext,
    output logic [WORD_LENGTH-1:0] imm_j_sext,
    output logic [WORD_LENGTH-1:0] out_pc,
    output logic                   illegal
);

    localparam logic [1:0] OP2_RS2 = 2'd0;
    localparam logic [1:0] OP2_IMI = 2'd1;
    localparam logic [1:0] OP2_IMS = 2'd2;
    localparam logic [1:0] OP2_IMJ = 2'd3;

    typedef struct packed {
        logic [1:0]             op2_sel;
        logic                   illegal;
        logic [WORD_LENGTH-1:0] rs2_data;
        logic [WORD_LENGTH-1:0] imm_i;
        logic [WORD_LENGTH-1:0] imm_s;
        logic [WORD_LENGTH-1:0] imm_j;
        logic [WORD_LENGTH-1:0] pc;
    } entry_t;

    entry_t     head_q, head_d, tail_q, tail_d, new_entry;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign rs2_addr = in_inst[24:20];

    always_comb begin
        new_entry          = '0;
        new_entry.rs2_data = rs2_rdata;
        new_entry.pc       = in_pc;
        new_entry.imm_i    = {{(WORD_LENGTH-12){in_inst[31]}}, in_inst[31:20]};
        new_entry.imm_s    = {{(WORD_LENGTH-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        new_entry.imm_j    = {{(WORD_LENGTH-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                              in_inst[20], in_inst[30:21], 1'b0};
        new_entry.op2_sel  = OP2_RS2;
        new_entry.illegal  = 1'b0;
        unique case (in_inst[6:0])
            7'b0110011, 7'b1100011:             new_entry.op2_sel = OP2_RS2;
            7'b0010011, 7'b0000011, 7'b1100111: new_entry.op2_sel = OP2_IMI;
            7'b0100011:                         new_entry.op2_sel = OP2_IMS;
            7'b1101111:                         new_entry.op2_sel = OP2_IMJ;
            default:                            new_entry.illegal = 1'b1;
        endcase
    end

    // in_ready depends on registered state only, never on out_ready.
    assign in_ready  = !rst && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_d  = new_entry;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_d = new_entry;
                    end else if (push) begin
                        tail_d  = new_entry;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign op2_sel    = head_q.op2_sel;
    assign illegal    = head_q.illegal;
    assign rs2_data   = head_q.rs2_data;
    assign imm_i_sext = head_q.imm_i;
    assign imm_s_sext = head_q.imm_s;
    assign imm_j_sext = head_q.imm_j;
    assign out_pc     = head_q.pc;

endmodule
